// File: rtl/cross_pkg.sv
// Shared constants, FSM/move encodings and the goal-column lookup for the
// player controller.
package cross_pkg;

    localparam logic [8:0] SPAWN_V    = 9'd460;
    localparam logic [9:0] SPAWN_H    = 10'd320;
    localparam logic [9:0] STEP       = 10'd40;
    localparam logic [8:0] TOP_LANE_V = 9'd60;
    localparam logic [8:0] GOAL_V     = 9'd20;
    localparam logic [9:0] H_MIN      = 10'd40;
    localparam logic [9:0] H_MAX      = 10'd600;
    localparam logic [9:0] GOAL_H0    = 10'd40;
    localparam logic [9:0] GOAL_H1    = 10'd320;
    localparam logic [9:0] GOAL_H2    = 10'd600;

    typedef enum logic [1:0] {IDLE, PLAY, GOAL, DONE} state_t;
    typedef enum logic [1:0] {NONE, UP, LEFT, RIGHT} move_t;

    // One-hot goal bit owned by column h; zero for non-goal columns.
    function automatic logic [2:0] goal_mask(input logic [9:0] h);
        logic [2:0] m;
        m = 3'b000;
        if (h == GOAL_H0) m = 3'b001;
        if (h == GOAL_H1) m = 3'b010;
        if (h == GOAL_H2) m = 3'b100;
        return m;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for one level key bit; the history flop makes a held
// key produce a single pulse.
module key_edge
(
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic key_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_q <= 1'b0;
        else      key_q <= key;
    end

    assign rise = key & ~key_q;

endmodule

// File: rtl/player_ctrl.sv
// Player position controller: key edges queue a single move that is applied
// on the next step tick, with goal tracking across three goal columns.
module player_ctrl
    import cross_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_tick,
    input  logic       key_up,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       collide,
    output logic [8:0] player_v,
    output logic [9:0] player_h,
    output logic [2:0] goal,
    output logic       started,
    output logic       finish
);

    localparam logic [8:0] STEP_V = STEP[8:0];

    logic   up_rise, left_rise, right_rise;
    state_t state_q, state_d;
    move_t  pending_q, pending_d, edge_move;
    logic [8:0] v_d;
    logic [9:0] h_d;
    logic [2:0] goal_d;
    logic       started_d, finish_d, goal_open;

    key_edge u_edge_up    (.clk(clk), .rst(rst), .key(key_up),    .rise(up_rise));
    key_edge u_edge_left  (.clk(clk), .rst(rst), .key(key_left),  .rise(left_rise));
    key_edge u_edge_right (.clk(clk), .rst(rst), .key(key_right), .rise(right_rise));

    always_comb begin
        edge_move = NONE;
        if (right_rise) edge_move = RIGHT;
        if (left_rise)  edge_move = LEFT;
        if (up_rise)    edge_move = UP;
    end

    assign goal_open = (goal_mask(player_h) & ~goal) != 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= NONE;
            player_v  <= SPAWN_V;
            player_h  <= SPAWN_H;
            goal      <= 3'b000;
            started   <= 1'b0;
            finish    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            player_v  <= v_d;
            player_h  <= h_d;
            goal      <= goal_d;
            started   <= started_d;
            finish    <= finish_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (up_rise) state_d = PLAY;
            PLAY: if (step_tick && !collide && pending_q == UP &&
                      player_v == TOP_LANE_V && goal_open) state_d = GOAL;
            GOAL: if (step_tick)
                      state_d = ((goal | goal_mask(player_h)) == 3'b111) ? DONE : PLAY;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // An edge only fills an empty slot; on a tick the slot is consumed first,
    // so an edge landing on the tick cycle waits for the following tick.
    always_comb begin
        v_d       = player_v;
        h_d       = player_h;
        goal_d    = goal;
        started_d = started;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                pending_d = NONE;
                if (up_rise) started_d = 1'b1;
            end
            PLAY: begin
                if (!step_tick) begin
                    if (pending_q == NONE) pending_d = edge_move;
                end else if (collide) begin
                    v_d       = SPAWN_V;
                    h_d       = SPAWN_H;
                    pending_d = NONE;
                end else begin
                    pending_d = (pending_q == NONE) ? edge_move : NONE;
                    case (pending_q)
                        UP: begin
                            if (player_v > TOP_LANE_V) v_d = player_v - STEP_V;
                            else if (goal_open)        v_d = GOAL_V;
                        end
                        LEFT:    if (player_h > H_MIN) h_d = player_h - STEP;
                        RIGHT:   if (player_h < H_MAX) h_d = player_h + STEP;
                        default: ;
                    endcase
                end
            end
            GOAL: begin
                pending_d = NONE;
                if (step_tick) begin
                    goal_d = goal | goal_mask(player_h);
                    v_d    = SPAWN_V;
                    h_d    = SPAWN_H;
                end
            end
            default: begin
                pending_d = NONE;
                v_d       = SPAWN_V;
                h_d       = SPAWN_H;
            end
        endcase
        finish_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: expected outputs are queued as each step is
// driven and compared once the DUT has reacted.
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_tick, key_up, key_left, key_right, collide;
    logic [8:0] player_v;
    logic [9:0] player_h;
    logic [2:0] goal;
    logic       started, finish;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [8:0] v;
        logic [9:0] h;
        logic [2:0] g;
        logic       s;
        logic       f;
    } exp_t;
    exp_t sb[$];

    player_ctrl dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .key_up(key_up),
        .key_left(key_left), .key_right(key_right), .collide(collide),
        .player_v(player_v), .player_h(player_h), .goal(goal),
        .started(started), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input string tag, input int v, input int h,
                           input int g, input int s, input int f);
        exp_t e;
        e.tag = tag;
        e.v   = 9'(v);
        e.h   = 10'(h);
        e.g   = 3'(g);
        e.s   = 1'(s);
        e.f   = 1'(f);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            assert ({player_v, player_h, goal, started, finish} === {e.v, e.h, e.g, e.s, e.f})
            else begin
                fails++;
                $error("[TB] FAIL %s: got v=%0d h=%0d goal=%b started=%b finish=%b, expected v=%0d h=%0d goal=%b started=%b finish=%b",
                       e.tag, player_v, player_h, goal, started, finish, e.v, e.h, e.g, e.s, e.f);
            end
        end
    endtask

    // One clock cycle with the given inputs; everything drops low afterwards.
    task automatic applyStimulus(input logic up, input logic left, input logic right,
                                 input logic tick, input logic col);
        key_up    = up;
        key_left  = left;
        key_right = right;
        step_tick = tick;
        collide   = col;
        @(posedge clk); #1;
        key_up = 0; key_left = 0; key_right = 0; step_tick = 0; collide = 0;
    endtask

    // dir: 0=up 1=left 2=right; each move is a press cycle then a tick cycle.
    task automatic moves(input int dir, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(dir == 0, dir == 1, dir == 2, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst = 0; step_tick = 0; key_up = 0; key_left = 0; key_right = 0; collide = 0;
        repeat (2) @(posedge clk);
        #1;
        pushExp("reset", 460, 320, 0, 0, 0); checkOutput();
        rst = 1;
        @(posedge clk); #1;

        pushExp("idle_tick", 460, 320, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("idle_left", 460, 320, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0); checkOutput();

        pushExp("start", 460, 320, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0); checkOutput();
        pushExp("first_tick", 460, 320, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("second_tick", 460, 320, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();

        pushExp("up_move", 420, 320, 0, 1, 0);
        key_up = 1;
        @(posedge clk); #1;
        step_tick = 1; @(posedge clk); #1; step_tick = 0;
        checkOutput();
        pushExp("up_held", 420, 320, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step_tick = 1; @(posedge clk); #1; step_tick = 0;
            @(posedge clk); #1;
        end
        checkOutput();
        key_up = 0;
        @(posedge clk); #1;

        pushExp("edge_on_tick", 420, 320, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput();
        pushExp("deferred_move", 420, 360, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();

        pushExp("right_to_max", 420, 600, 0, 1, 0);
        moves(2, 6); checkOutput();
        pushExp("right_clamp", 420, 600, 0, 1, 0);
        moves(2, 1); checkOutput();
        pushExp("left_to_min", 420, 40, 0, 1, 0);
        moves(1, 14); checkOutput();
        pushExp("left_clamp", 420, 40, 0, 1, 0);
        moves(1, 1); checkOutput();
        pushExp("at_100_200", 100, 200, 0, 1, 0);
        moves(2, 4); moves(0, 8); checkOutput();

        pushExp("up_beats_left", 60, 200, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("collide", 460, 320, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 0, 1, 1); checkOutput();
        pushExp("after_collide", 460, 320, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();

        pushExp("top_lane", 60, 320, 0, 1, 0);
        moves(0, 10); checkOutput();
        pushExp("goal1_entry", 20, 320, 0, 1, 0);
        moves(0, 1); checkOutput();
        pushExp("goal1", 460, 320, 3'b010, 1, 0);
        applyStimulus(0, 1, 0, 0, 0); applyStimulus(0, 0, 0, 1, 1); checkOutput();
        pushExp("goal_left_dropped", 460, 320, 3'b010, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("goal1_blocked", 60, 320, 3'b010, 1, 0);
        moves(0, 11); checkOutput();

        pushExp("second_edge_dropped", 60, 280, 3'b010, 1, 0);
        applyStimulus(0, 1, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("no_pending", 60, 280, 3'b010, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();

        pushExp("goal0_entry", 20, 40, 3'b010, 1, 0);
        moves(1, 6); moves(0, 1); checkOutput();
        pushExp("goal0", 460, 320, 3'b011, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();

        pushExp("goal2_entry", 20, 600, 3'b011, 1, 0);
        moves(2, 7); moves(0, 11); checkOutput();
        pushExp("finish", 460, 320, 3'b111, 1, 1);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("done_up", 460, 320, 3'b111, 1, 1);
        moves(0, 1); checkOutput();
        pushExp("done_left", 460, 320, 3'b111, 1, 1);
        moves(1, 1); checkOutput();

        pushExp("async_reset", 460, 320, 0, 0, 0);
        rst = 0; #1; checkOutput();
        @(posedge clk); #1;
        rst = 1;
        pushExp("post_reset_tick", 460, 320, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput();
        pushExp("restart", 460, 320, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0); checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
